// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg : shared types and widths for the matrix-engine job scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mm_pkg;

  localparam int unsigned MM_ADDR_W = 20;
  localparam int unsigned MM_ID_W   = 4;
  localparam int unsigned MM_WDOG_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } mm_state_e;

  typedef struct packed {
    logic [MM_ID_W-1:0]   id;
    logic [MM_ADDR_W-1:0] base;
  } mm_job_t;

  // Occupancy counter width: one extra bit so "full" (== depth) is representable.
  function automatic int unsigned mm_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mm_job_fifo.sv
// ---------------------------------------------------------------------------
// mm_job_fifo : synchronous job queue, DEPTH entries (power of two)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mm_job_fifo
  import mm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push_i,
  input  mm_job_t                          push_data_i,
  input  logic                             pop_i,
  output mm_job_t                          pop_data_o,
  output logic [mm_cnt_w(DEPTH)-1:0]       count_o,
  output logic                             empty_o,
  output logic                             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = mm_cnt_w(DEPTH);

  mm_job_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are exactly log2(DEPTH) wide, so the increment wraps naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mm_job_sched.sv
// ---------------------------------------------------------------------------
// mm_job_sched : queues host jobs and sequences them through a matrix engine.
// Optional watchdog timeout enabled by defining MM_WDOG_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mm_job_sched
  import mm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] WDOG_LIMIT = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [MM_ID_W-1:0]   job_id,
  input  logic [MM_ADDR_W-1:0] job_base,
  output logic                 mm_clear,
  output logic                 mm_start,
  output logic [MM_ADDR_W-1:0] mm_base,
  input  logic                 mm_finish,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [MM_ID_W-1:0]   done_id,
  output logic                 done_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = mm_cnt_w(FIFO_DEPTH);

  mm_state_e        state_q, state_d;
  mm_job_t          active_q, active_d;
  logic             err_q, err_d;
  logic             run_first_q, run_first_d;

  mm_job_t          fifo_in;
  mm_job_t          fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;
  logic             timeout;

  assign fifo_in   = '{id: job_id, base: job_base};
  assign job_ready = !fifo_full;
  assign fifo_push = job_valid && job_ready;
  assign fifo_pop  = (state_q == IDLE) && (fifo_count != '0);

  mm_job_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

`ifdef MM_WDOG_EN
  logic [MM_WDOG_W-1:0] wdog_q, wdog_d;

  // A finish arriving in the expiry cycle wins, so timeout is masked by it.
  assign timeout = (state_q == RUN) && !mm_finish && (wdog_q == WDOG_LIMIT);

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == CLEAR)    wdog_d = '0;
    else if (state_q == RUN) wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  logic unused_wdog_limit;

  assign timeout           = 1'b0;
  assign unused_wdog_limit = ^WDOG_LIMIT;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_count != '0)      state_d = CLEAR;
      CLEAR:                              state_d = RUN;
      RUN:     if (mm_finish || timeout)  state_d = REPORT;
      REPORT:  if (done_ready)            state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_comb begin
    mm_clear   = 1'b0;
    mm_start   = 1'b0;
    done_valid = 1'b0;
    case (state_q)
      CLEAR:   mm_clear   = 1'b1;
      RUN: begin
        mm_start = run_first_q;
        mm_clear = timeout;
      end
      REPORT:  done_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    active_d    = active_q;
    err_d       = err_q;
    run_first_d = (state_q == CLEAR);
    if (fifo_pop) begin
      active_d = fifo_head;
      err_d    = 1'b0;
    end
    if (state_q == RUN) begin
      if (mm_finish)    err_d = 1'b0;
      else if (timeout) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q    <= '0;
      err_q       <= 1'b0;
      run_first_q <= 1'b0;
    end else begin
      active_q    <= active_d;
      err_q       <= err_d;
      run_first_q <= run_first_d;
    end
  end

  // Record fields come straight from the held job, so they are stable in REPORT.
  assign mm_base  = active_q.base;
  assign done_id  = active_q.id;
  assign done_err = err_q;
  assign busy     = !fifo_empty || (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mm_job_sched.sv
// ---------------------------------------------------------------------------
// tb_mm_job_sched : directed and randomized self-checking bench for mm_job_sched
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mm_job_sched;

  localparam int unsigned FIFO_DEPTH = 4;
`ifdef MM_WDOG_EN
  localparam logic [15:0] TB_WDOG = 16'd8;
`else
  localparam logic [15:0] TB_WDOG = 16'hFFFF;
`endif

  typedef struct {
    logic [3:0]  id;
    logic [19:0] base;
  } tb_job_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [3:0]  job_id = '0;
  logic [19:0] job_base = '0;
  logic        mm_clear;
  logic        mm_start;
  logic [19:0] mm_base;
  logic        mm_finish = 1'b0;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic [3:0]  done_id;
  logic        done_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mm_job_sched #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WDOG_LIMIT (TB_WDOG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_id     (job_id),
    .job_base   (job_base),
    .mm_clear   (mm_clear),
    .mm_start   (mm_start),
    .mm_base    (mm_base),
    .mm_finish  (mm_finish),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .done_id    (done_id),
    .done_err   (done_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL tb_timeout: observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {2'b00, job_ready, mm_clear, mm_start, mm_base, done_valid, done_id, done_err, busy};
  endfunction

  task automatic push(input logic [3:0] id, input logic [19:0] base);
    job_valid = 1'b1;
    job_id    = id;
    job_base  = base;
    chk("push_ready", 32'(job_ready), 32'd1);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!mm_start && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 32'(mm_start), 32'd1);
  endtask

  task automatic run_job(input logic [3:0] id, input logic [19:0] base, input int delay);
    int n = 0;
    while (!mm_clear && n < 30) begin
      tick();
      n++;
    end
    chk("job_clear", 32'(mm_clear), 32'd1);
    chk("job_base", 32'(mm_base), 32'(base));
    tick();
    chk("job_start", 32'(mm_start), 32'd1);
    repeat (delay) tick();
    mm_finish = 1'b1;
    tick();
    mm_finish = 1'b0;
    chk("job_done_valid", 32'(done_valid), 32'd1);
    chk("job_done_id", 32'(done_id), 32'(id));
    chk("job_done_err", 32'(done_err), 32'd0);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("job_done_drop", 32'(done_valid), 32'd0);
  endtask

  initial begin
    tb_job_t q[$];
    tb_job_t cur;
    tb_job_t pend_job;
    bit      in_flight, in_run, pend_push, pend_hs, drain, stable;
    int      run_left, accepted, completed;

    // Reset state
    #23;
    chk("reset_outputs", outs(), 32'h2000_0000);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("post_reset_outputs", outs(), 32'h2000_0000);

    // Single job latency and record
    job_valid = 1'b1; job_id = 4'd3; job_base = 20'h00010;
    chk("lat_ready", 32'(job_ready), 32'd1);
    tick();                                   // edge N
    job_valid = 1'b0;
    chk("lat_n_clear", 32'(mm_clear), 32'd0);
    chk("lat_n_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_clear", 32'(mm_clear), 32'd1);
    chk("lat_clear_start", 32'(mm_start), 32'd0);
    chk("lat_base", 32'(mm_base), 32'h10);
    tick();
    chk("lat_start", 32'(mm_start), 32'd1);
    chk("lat_start_clear", 32'(mm_clear), 32'd0);
    repeat (7) tick();
    mm_finish = 1'b1;
    chk("lat_no_early_done", 32'(done_valid), 32'd0);
    tick();                                   // edge N+10
    mm_finish = 1'b0;
    chk("lat_done", {27'd0, done_valid, done_id, done_err}, {27'd0, 1'b1, 4'd3, 1'b0});
    chk("lat_base_hold", 32'(mm_base), 32'h10);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("lat_idle", {30'd0, done_valid, busy}, 32'd0);

    // Finish pulse while idle is ignored
    mm_finish = 1'b1;
    tick();
    mm_finish = 1'b0;
    repeat (3) tick();
    chk("idle_finish", {29'd0, done_valid, busy, mm_clear}, 32'd0);

    // Queue fill with engine stalled on a blocker job
    push(4'd9, 20'h00900);
    wait_start("fill_blocker_start");
    for (int k = 0; k < 5; k++) begin
      job_valid = 1'b1;
      job_id    = 4'(k);
      job_base  = 20'h01000 + 20'(k);
      chk("fill_ready", 32'(job_ready), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    job_valid = 1'b0;
    mm_finish = 1'b1;
    tick();
    mm_finish = 1'b0;
    chk("fill_blocker_id", 32'(done_id), 32'd9);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    for (int k = 0; k < 4; k++) run_job(4'(k), 20'h01000 + 20'(k), 1);
    repeat (4) tick();
    chk("fill_no_fifth", {30'd0, mm_clear, busy}, 32'd0);

    // Held completion record
    push(4'hA, 20'h0AAAA);
    push(4'hB, 20'h0BBBB);
    wait_start("hold_start");
    mm_finish = 1'b1;
    tick();
    mm_finish = 1'b0;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!(done_valid && done_id == 4'hA && !done_err && !mm_clear)) stable = 1'b0;
      tick();
    end
    chk("hold_stable", 32'(stable), 32'd1);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    run_job(4'hB, 20'h0BBBB, 2);

`ifdef MM_WDOG_EN
    // Watchdog expiry, then finish coinciding with expiry
    push(4'd7, 20'h00777);
    wait_start("wdog_start");
    repeat (7) tick();
    chk("wdog_not_early", 32'(mm_clear), 32'd0);
    tick();
    chk("wdog_clear_pulse", {30'd0, mm_clear, done_valid}, 32'h2);
    tick();
    chk("wdog_report", {26'd0, mm_clear, done_valid, done_id, done_err}, {26'd0, 1'b0, 1'b1, 4'd7, 1'b1});
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    push(4'd6, 20'h00666);
    wait_start("wdog2_start");
    repeat (8) tick();
    mm_finish = 1'b1;
    #1;
    chk("wdog_tie_no_clear", 32'(mm_clear), 32'd0);
    tick();
    mm_finish = 1'b0;
    chk("wdog_tie_report", {27'd0, done_valid, done_id, done_err}, {27'd0, 1'b1, 4'd6, 1'b0});
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
`else
    // Without the watchdog a stalled engine never times out
    push(4'd7, 20'h00777);
    wait_start("nowdog_start");
    repeat (40) tick();
    chk("nowdog_stall", {30'd0, mm_clear, done_valid}, 32'd0);
    mm_finish = 1'b1;
    tick();
    mm_finish = 1'b0;
    chk("nowdog_report", {27'd0, done_valid, done_id, done_err}, {27'd0, 1'b1, 4'd7, 1'b0});
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
`endif

    // Reset during RUN with two jobs queued
    push(4'hC, 20'h00123);
    wait_start("rst_start");
    push(4'hD, 20'h00456);
    push(4'hE, 20'h00789);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_outputs", outs(), 32'h2000_0000);
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
    stable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (done_valid || mm_clear || busy) stable = 1'b0;
      tick();
    end
    chk("rst_discarded", 32'(stable), 32'd1);

    // Randomized traffic against a queue-level model
    in_flight = 0; in_run = 0; pend_push = 0; pend_hs = 0;
    run_left = 0; accepted = 0; completed = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      drain = (cyc >= 450);
      if (pend_push) q.push_back(pend_job);
      if (pend_hs) begin
        in_flight = 0;
        completed++;
      end
      if (drain && q.size() == 0 && !in_flight) break;
      if (mm_clear) begin
        chk("rnd_clear_has_job", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) cur = q.pop_front();
        in_flight = 1;
      end
      chk("rnd_ready", 32'(job_ready), 32'(q.size() < FIFO_DEPTH));
      chk("rnd_busy", 32'(busy), 32'(q.size() > 0 || in_flight));
      if (in_flight) chk("rnd_base", 32'(mm_base), 32'(cur.base));
      if (mm_start) begin
        chk("rnd_start_in_job", 32'(in_flight && !in_run), 32'd1);
        in_run   = 1;
        run_left = $urandom_range(0, 5);
      end
      if (done_valid) begin
        chk("rnd_done_id", 32'(done_id), 32'(cur.id));
        chk("rnd_done_err", 32'(done_err), 32'd0);
      end
      mm_finish = 1'b0;
      if (in_run) begin
        if (run_left == 0) begin
          mm_finish = 1'b1;
          in_run    = 0;
        end else begin
          run_left--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mm_finish = 1'b1;
      end
      done_ready    = 1'($urandom_range(0, 1));
      pend_hs       = done_valid && done_ready;
      job_valid     = drain ? 1'b0 : 1'($urandom_range(0, 1));
      job_id        = 4'($urandom());
      job_base      = 20'($urandom());
      pend_push     = job_valid && job_ready;
      pend_job.id   = job_id;
      pend_job.base = job_base;
      if (pend_push) accepted++;
      tick();
    end
    mm_finish  = 1'b0;
    done_ready = 1'b0;
    job_valid  = 1'b0;
    chk("rnd_all_completed", 32'(completed), 32'(accepted));
    chk("rnd_final_idle", {30'd0, busy, done_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mm_job_sched.md
MM_JOB_SCHED -- requirements
Module: mm_job_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: job queue entries, power of two.
REQ-002 SHALL have parameter WDOG_LIMIT, default 16'hFFFF: RUN-state cycle limit before timeout.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port job_valid  in  1  host offers a job.
REQ-006 SHALL have port job_ready  out  1  queue can accept a job.
REQ-007 SHALL have port job_id  in  4  job tag.
REQ-008 SHALL have port job_base  in  20  matrix base offset for the engine.
REQ-009 SHALL have port mm_clear  out  1  one-cycle clear pulse to the matrix engine.
REQ-010 SHALL have port mm_start  out  1  one-cycle start pulse to the engine.
REQ-011 SHALL have port mm_base  out  20  base offset of the active job.
REQ-012 SHALL have port mm_finish  in  1  engine completion flag.
REQ-013 SHALL have port done_valid  out  1  completion record available.
REQ-014 SHALL have port done_ready  in  1  host accepts the completion record.
REQ-015 SHALL have port done_id  out  4  tag of the completed job.
REQ-016 SHALL have port done_err  out  1  1 = job ended by watchdog timeout.
REQ-017 SHALL have port busy  out  1  queue non-empty or state not IDLE.

Function
REQ-018 SHALL push {job_id, job_base} when job_valid && job_ready; job_ready = (count != FIFO_DEPTH), taken from the registered count only.
REQ-019 SHALL ignore job_valid while the queue is full; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-020 SHALL use the FSM states IDLE, CLEAR, RUN and REPORT.
REQ-021 SHALL, in IDLE with count > 0, pop the head into active_id/active_base and go to CLEAR; with count == 0 it SHALL stay in IDLE.
REQ-022 SHALL assert mm_clear=1 for exactly the one CLEAR cycle, then go to RUN.
REQ-023 SHALL assert mm_start=1 only in the first RUN cycle and SHALL clear the watchdog counter on RUN entry.
REQ-024 SHALL, in RUN with mm_finish=1, go to REPORT with done_err=0; mm_finish outside RUN SHALL be ignored.
REQ-025 SHALL hold mm_base = active_base from CLEAR through REPORT, stable for the whole job.
REQ-026 SHALL, in REPORT, drive done_valid=1 with stable done_id/done_err until done_ready=1, then go to IDLE.
REQ-027 SHALL produce this latency: job accepted at edge N gives mm_clear in cycle N+2 and mm_start in cycle N+3, when IDLE and the queue is empty.
REQ-028 SHALL let done_ready=1 outside REPORT have no effect.
REQ-029 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-030 SHALL, on reset low and asynchronously, set state=IDLE, count=0, pointers=0 and the watchdog counter to 0.
REQ-031 SHALL use these output reset values: job_ready=1, mm_clear=0, mm_start=0, mm_base=0, done_valid=0, done_id=0, done_err=0, busy=0.
REQ-032 SHALL, on reset mid-job, discard the active and queued jobs with no done record.

Configuration
REQ-033 SHALL, with MM_WDOG_EN defined, count RUN cycles in a 16-bit counter.
REQ-034 SHALL, with MM_WDOG_EN defined and the counter equal to WDOG_LIMIT, pulse mm_clear for one cycle and go to REPORT with done_err=1.
REQ-035 SHALL give mm_finish priority over timeout when both occur in the same cycle, producing done_err=0.
REQ-036 SHALL, without MM_WDOG_EN, contain no counter, hold done_err=0 and never leave RUN except on mm_finish.

Structure
REQ-037 SHALL take from shared package mm_pkg: the state enum (IDLE/CLEAR/RUN/REPORT), MM_ADDR_W=20, MM_ID_W=4 and the job record typedef {id, base}.
REQ-038 SHALL instantiate sub-module mm_job_fifo (sync FIFO, FIFO_DEPTH entries, with push, pop, count, empty and full).

Verification
REQ-039 SHALL verify: push id=3, base=0x00010 into an idle block -> mm_clear in cycle N+2, mm_start in cycle N+3, mm_base=0x00010; finish at N+10 -> done_valid=1, done_id=3, done_err=0.
REQ-040 SHALL verify: push 5 jobs back-to-back with the engine stalled -> 4 accepted, job_ready=0 on the 5th; jobs complete in FIFO order with ids 0,1,2,3.
REQ-041 SHALL verify: hold done_ready=0 for 20 cycles in REPORT -> done_valid, done_id and done_err stay stable; next mm_clear comes only after the handshake.
REQ-042 SHALL verify, with MM_WDOG_EN and WDOG_LIMIT=8: withhold mm_finish -> timeout with mm_clear pulse, done_err=1; mm_finish and expiry in the same cycle -> done_err=0.
REQ-043 SHALL verify: assert reset low during RUN with 2 jobs queued -> all outputs reach reset values immediately, busy=0, no done_valid after release.
REQ-044 SHALL verify: pulse mm_finish while IDLE -> no state change and no done_valid.
